// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - microcode word fields, opcodes and sequencer states for the SSD1306 init sequencer
package ssd1306_pkg;

  localparam int OPCODE_MSB = 9;
  localparam int OPCODE_LSB = 8;
  localparam int PAYLOAD_W  = 8;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/ssd1306_delay_timer.sv
// rtl/ssd1306_delay_timer.sv - tick prescaler plus 8-bit unit down-counter for DELAY microcode words
module ssd1306_delay_timer
  import ssd1306_pkg::*;
#(
  parameter int DELAY_TICK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] units,
  output logic                 expired
);

  localparam int PW = $clog2(DELAY_TICK_CYCLES + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(DELAY_TICK_CYCLES - 1);

  logic [PW-1:0]        prescale_q;
  logic [PAYLOAD_W-1:0] units_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q <= '0;
      units_q    <= '0;
    end else if (load) begin
      prescale_q <= '0;
      units_q    <= units;
    end else if (units_q != '0) begin
      if (prescale_q == TICK_LAST) begin
        prescale_q <= '0;
        units_q    <= units_q - 1'b1;
      end else begin
        prescale_q <= prescale_q + 1'b1;
      end
    end
  end

  assign expired = (units_q == '0);

endmodule

// File: rtl/ssd1306_microcode_sequencer.sv
// rtl/ssd1306_microcode_sequencer.sv - walks the SSD1306 microcode ROM, emitting bytes and timed delays
// Optional DELAY execution (timer) is enabled by defining SSD1306_SEQ_DELAY_EN; otherwise DELAY is a NOP.
module ssd1306_microcode_sequencer
  import ssd1306_pkg::*;
#(
  parameter int  ROM_SIZE          = 40,
  parameter int  DELAY_TICK_CYCLES = 1000,
  localparam int ADDRESS_BITS      = $clog2(ROM_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [ADDRESS_BITS-1:0] rom_address,
  input  logic [9:0]              rom_data,
  input  logic                    rom_overflow,
  output logic [7:0]              tx_data,
  output logic                    tx_dc,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  seq_state_t            state_q;
  logic                  busy_q, done_q, overrun_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [PAYLOAD_W-1:0]  tx_data_q;
  logic                  tx_dc_q, tx_valid_q;

  opcode_t               op;
  logic [PAYLOAD_W-1:0]  payload;
  logic                  at_last;
  logic                  advance;

  assign op      = opcode_t'(rom_data[OPCODE_MSB:OPCODE_LSB]);
  assign payload = rom_data[PAYLOAD_W-1:0];
  assign at_last = (addr_q == {ADDRESS_BITS{1'b1}});

`ifdef SSD1306_SEQ_DELAY_EN
  logic timer_load, timer_expired;

  assign timer_load = (state_q == ST_FETCH) && !rom_overflow && (op == OP_DELAY);

  ssd1306_delay_timer #(
    .DELAY_TICK_CYCLES(DELAY_TICK_CYCLES)
  ) u_delay_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .units  (payload),
    .expired(timer_expired)
  );
`else
  // The tick parameter only sizes the timer, which this build omits.
  if (DELAY_TICK_CYCLES < 1) begin : g_tick_unused
  end
`endif

  always_comb begin
    advance = 1'b0;
    case (state_q)
      ST_SEND:  advance = tx_ready;
`ifdef SSD1306_SEQ_DELAY_EN
      ST_WAIT:  advance = timer_expired;
`else
      ST_FETCH: advance = !rom_overflow && (op == OP_DELAY);
`endif
      default:  advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_dc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_q    <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rom_overflow) begin
            overrun_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            case (op)
              OP_CMD, OP_DATA: begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= payload;
                tx_dc_q    <= rom_data[OPCODE_LSB];
                state_q    <= ST_SEND;
              end
              OP_DELAY: begin
`ifdef SSD1306_SEQ_DELAY_EN
                state_q <= ST_WAIT;
`endif
              end
              default: begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_SEND: begin
          if (tx_ready) tx_valid_q <= 1'b0;
        end
        default: ;
      endcase

      // Running off the top of the address space is an overrun, never a wrap.
      if (advance) begin
        if (at_last) begin
          overrun_q <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end else begin
          addr_q  <= addr_q + 1'b1;
          state_q <= ST_FETCH;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign rom_address = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_dc       = tx_dc_q;
  assign tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_ssd1306_microcode_sequencer.sv
// tb/tb_ssd1306_microcode_sequencer.sv - table-driven scoreboard bench for the SSD1306 microcode sequencer
`timescale 1ns/1ps
module tb_ssd1306_microcode_sequencer;
  localparam int ROM_SIZE = 40;
  localparam int TICKS    = 4;
  localparam int AB       = $clog2(ROM_SIZE);
`ifdef SSD1306_SEQ_DELAY_EN
  localparam int LAT_D3 = 16;
  localparam int LAT_D0 = 4;
`else
  localparam int LAT_D3 = 3;
  localparam int LAT_D0 = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tx_ready = 1'b0;
  logic          busy, done, overrun, tx_dc, tx_valid, rom_overflow;
  logic [AB-1:0] rom_address;
  logic [9:0]    rom_data;
  logic [7:0]    tx_data;
  logic [9:0]    rom [64];

  assign rom_data     = rom[rom_address];
  assign rom_overflow = (int'(rom_address) >= ROM_SIZE);

  always #5 clk = ~clk;

  ssd1306_microcode_sequencer #(
    .ROM_SIZE(ROM_SIZE),
    .DELAY_TICK_CYCLES(TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .overrun(overrun),
    .rom_address(rom_address), .rom_data(rom_data), .rom_overflow(rom_overflow),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  typedef struct {
    logic [3:0][9:0] prog;
    int              nexp;
    logic [1:0][8:0] exp;
    logic            stall;
    int              lat;
    logic            ov;
  } vec_t;

  vec_t       vecs[6];
  logic [8:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic vec_t mk(input logic [9:0] w0, w1, w2, w3, input int nexp,
                              input logic [8:0] e0, e1, input logic stall, input int lat,
                              input logic ov);
    vec_t v;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
    v.nexp = nexp; v.exp[0] = e0; v.exp[1] = e1;
    v.stall = stall; v.lat = lat; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic load_prog(input logic [3:0][9:0] p);
    for (int i = 0; i < 64; i++) rom[i] = (i < 4) ? p[i] : 10'h300;
  endtask

  // Pulses start, then drives tx_ready and scores every accepted byte until done.
  task automatic run_seq(input logic stall, input int lat, input logic ov, input string tag);
    int         edges = 0;
    int         stall_cnt = 0;
    int         got_lat = 0;
    logic       prev_hold = 1'b0;
    logic [8:0] prev_b = '0;
    logic [8:0] e;
    @(negedge clk);
    start = 1'b1;
    tx_ready = 1'b1;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (edges == 1) check({tag, " busy/done/overrun after start"}, {busy, done, overrun}, 3'b100);
      if (prev_hold) check({tag, " byte held"}, {tx_valid, tx_dc, tx_data}, {1'b1, prev_b});
      if (tx_valid && got_lat == 0) got_lat = edges;
      tx_ready = 1'b1;
      if (stall && got_lat != 0 && stall_cnt < 5) begin
        tx_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == 3) start = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s extra byte: got %0h, want none", tag, {tx_dc, tx_data});
        end else begin
          e = exp_q.pop_front();
          check({tag, " byte"}, {tx_dc, tx_data}, e);
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_b = {tx_dc, tx_data};
      if (done) break;
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy at end"}, busy, 1'b0);
    check({tag, " overrun"}, overrun, ov);
    check({tag, " first byte latency"}, got_lat, lat);
    check({tag, " bytes left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = mk(10'h0AE, 10'h1FF, 10'h300, 10'h300, 2, 9'h0AE, 9'h1FF, 1'b0, 2, 1'b0);
    vecs[1] = mk(10'h0AE, 10'h1FF, 10'h300, 10'h300, 2, 9'h0AE, 9'h1FF, 1'b1, 2, 1'b0);
    vecs[2] = mk(10'h203, 10'h0AF, 10'h300, 10'h300, 1, 9'h0AF, 9'h000, 1'b0, LAT_D3, 1'b0);
    vecs[3] = mk(10'h200, 10'h1A5, 10'h300, 10'h300, 1, 9'h1A5, 9'h000, 1'b0, LAT_D0, 1'b0);
    vecs[4] = mk(10'h300, 10'h300, 10'h300, 10'h300, 0, 9'h000, 9'h000, 1'b0, 0, 1'b0);
    vecs[5] = mk(10'h012, 10'h201, 10'h134, 10'h300, 2, 9'h012, 9'h134, 1'b0, 2, 1'b0);

    load_prog(vecs[0].prog);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", {busy, done, overrun, tx_valid, tx_dc, tx_data, rom_address}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load_prog(vecs[i].prog);
      for (int k = 0; k < vecs[i].nexp; k++) exp_q.push_back(vecs[i].exp[k]);
      run_seq(vecs[i].stall, vecs[i].lat, vecs[i].ov, $sformatf("v%0d", i));
    end

    // Full ROM of CMD words with no END, then a clean restart.
    for (int i = 0; i < 64; i++) rom[i] = (i < ROM_SIZE) ? 10'(i) : 10'h300;
    for (int i = 0; i < ROM_SIZE; i++) exp_q.push_back({1'b0, 8'(i)});
    run_seq(1'b0, 2, 1'b1, "overrun");
    load_prog(vecs[0].prog);
    exp_q.push_back(9'h0AE);
    exp_q.push_back(9'h1FF);
    run_seq(1'b0, 2, 1'b0, "overrun restart");

    // Reset while the second byte is waiting for acceptance.
    load_prog(vecs[0].prog);
    @(negedge clk);
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid && tx_dc) begin
        tx_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("mid-send byte pending", {tx_valid, tx_dc, tx_data, rom_address}, {2'b11, 8'hFF, 6'd1});
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-send reset", {tx_valid, busy, done, rom_address}, '0);
    rst_n = 1'b1;
    exp_q.push_back(9'h0AE);
    exp_q.push_back(9'h1FF);
    run_seq(1'b0, 2, 1'b0, "reset restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
